sd_wrr_sched: RTL

Weighted round-robin scheduler sharing one srdy/drdy output channel, such as the input of an sd_pipeline closure or a FIFO, between `inputs` independent srdy/drdy producers. Each granted producer may send a burst of up to its configured weight in beats before the grant rotates. The output is a single registered stage, so the block sits directly in front of the shared datapath. Each output beat carries the index of its source.

---
 rtl/sd_wrr_sched.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sd_wrr_sched.sv
// Weighted round-robin scheduler: shares one registered srdy/drdy output stage between
// several srdy/drdy producers, granting each a burst of up to its configured weight.
module sd_wrr_sched #(
  parameter int width  = 8,
  parameter int inputs = 4,
  parameter int wbits  = 4,
  localparam int isz   = $clog2(inputs)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [inputs-1:0]         c_srdy,
  output logic [inputs-1:0]         c_drdy,
  input  logic [inputs*width-1:0]   c_data,
  input  logic [inputs*wbits-1:0]   cfg_weight,
  output logic                      p_srdy,
  output logic [width-1:0]          p_data,
  output logic [isz-1:0]            p_grant,
  input  logic                      p_drdy
);

  localparam logic StIdle  = 1'b0;
  localparam logic StBurst = 1'b1;

  logic             state;
  logic [isz-1:0]   grant;
  logic [isz-1:0]   ptr;
  logic [wbits-1:0] cnt;
  logic [wbits-1:0] wlim;

  logic [inputs-1:0] elig;
  logic              found;
  logic [isz-1:0]    pick_idx;
  logic [wbits-1:0]  pick_w;
  logic              cur_srdy;
  logic [width-1:0]  cur_data;
  logic              load_ok;
  logic              xfer;
  logic              rel;
  logic [wbits-1:0]  cnt_inc;
  logic [isz-1:0]    ptr_nxt;

  always_comb begin
    for (int i = 0; i < inputs; i++) begin
      elig[i] = c_srdy[i] & (cfg_weight[i*wbits +: wbits] != '0);
    end
  end

  // Two passes give a rotating priority search starting at ptr: first ptr..inputs-1, then 0..ptr-1.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < inputs; i++) begin
      if (!found && elig[i] && (isz'(i) >= ptr)) begin
        found    = 1'b1;
        pick_idx = isz'(i);
      end
    end
    for (int i = 0; i < inputs; i++) begin
      if (!found && elig[i]) begin
        found    = 1'b1;
        pick_idx = isz'(i);
      end
    end
  end

  always_comb begin
    pick_w   = '0;
    cur_srdy = 1'b0;
    cur_data = '0;
    for (int i = 0; i < inputs; i++) begin
      if (pick_idx == isz'(i)) pick_w = cfg_weight[i*wbits +: wbits];
      if (grant == isz'(i)) begin
        cur_srdy = c_srdy[i];
        cur_data = c_data[i*width +: width];
      end
    end
  end

  assign load_ok = ~p_srdy | p_drdy;
  assign xfer    = (state == StBurst) & cur_srdy & load_ok;
  assign cnt_inc = cnt + 1'b1;
  // A stalled output freezes the burst only while the granted source keeps srdy high.
  assign rel     = (state == StBurst) & ((xfer & (cnt_inc == wlim)) | ~cur_srdy);
  assign ptr_nxt = (grant == isz'(inputs - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    c_drdy = '0;
    if (reset && (state == StBurst) && load_ok) begin
      for (int i = 0; i < inputs; i++) begin
        c_drdy[i] = (grant == isz'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= StIdle;
      grant   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      wlim    <= '0;
      p_srdy  <= 1'b0;
      p_data  <= '0;
      p_grant <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (found) begin
            grant <= pick_idx;
            wlim  <= pick_w;
            cnt   <= '0;
            state <= StBurst;
          end
        end
        StBurst: begin
          if (xfer) cnt <= cnt_inc;
          if (rel) begin
            ptr   <= ptr_nxt;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase

      if (xfer) begin
        p_srdy  <= 1'b1;
        p_data  <= cur_data;
        p_grant <= grant;
      end else if (p_drdy) begin
        p_srdy  <= 1'b0;
      end
    end
  end

endmodule
